// File: rtl/overlap_framer_if.sv
// Sample-in / frame-out signal bundle of the overlapping framer.
// The source side uses the master modport; the framer uses the slave modport.
interface overlap_framer_if #(
    parameter int DATA_W      = 14,
    parameter int FRAME_LEN   = 1024,
    parameter int FRAME_CNT_W = 16
);
    localparam int NUM_W = $clog2(FRAME_LEN);

    logic [1:0]               di_en;
    logic signed [DATA_W-1:0] data_i;
    logic [FRAME_CNT_W-1:0]   cfg_n_frames;
    logic [1:0]               do_en;
    logic signed [DATA_W-1:0] data_o;
    logic [NUM_W-1:0]         num;
    logic                     frame_last;
    logic [FRAME_CNT_W-1:0]   frame_idx;
    logic                     done;
    logic                     ovf;

    modport master (
        output di_en, data_i, cfg_n_frames,
        input  do_en, data_o, num, frame_last, frame_idx, done, ovf
    );

    modport slave (
        input  di_en, data_i, cfg_n_frames,
        output do_en, data_o, num, frame_last, frame_idx, done, ovf
    );
endinterface

// File: rtl/overlap_framer.sv
// Buffers signed samples in a circular store and emits overlapping frames of FRAME_LEN
// samples every HOP_LEN accepted samples, with a one-deep pending-frame queue.
module overlap_framer #(
    parameter int DATA_W      = 14,
    parameter int FRAME_LEN   = 1024,
    parameter int HOP_LEN     = 160,
    parameter int FRAME_CNT_W = 16
) (
    input logic             clk,
    input logic             rst,
    overlap_framer_if.slave bus
);
    localparam int DEPTH  = FRAME_LEN + 2 * HOP_LEN;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int NUM_W  = $clog2(FRAME_LEN);
    localparam int HOP_W  = $clog2(HOP_LEN + 1);

    typedef enum logic [1:0] {FILL, EMIT, GAP, STOP} state_t;

    logic signed [DATA_W-1:0] mem [DEPTH];
    state_t                   state, state_nx;
    logic [ADDR_W-1:0]        wr_ptr, wr_next, rd_ptr, rd_next;
    logic [ADDR_W-1:0]        pend_addr, trig_addr, start_addr;
    logic [ADDR_W:0]          start_sum;
    logic [NUM_W-1:0]         fill_cnt, emit_cnt;
    logic [HOP_W-1:0]         hop_cnt;
    logic                     filled, pending, started;
    logic [FRAME_CNT_W-1:0]   n_frames_q, frame_idx;
    logic                     accept, trig, last_beat, final_frame;
    logic                     start_frame, pend_set, pend_clr, ovf_set;
    logic signed [DATA_W-1:0] rd_data, data_o;
    logic [1:0]               do_en;
    logic [NUM_W-1:0]         num;
    logic                     frame_last, done, ovf;

    assign accept    = (bus.di_en == 2'd1);
    assign wr_next   = (wr_ptr == ADDR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
    assign rd_next   = (rd_ptr == ADDR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
    // Start of the frame ending with the sample just accepted: (wr_ptr + 1 - FRAME_LEN) mod DEPTH.
    assign start_sum = {1'b0, wr_next} + (ADDR_W + 1)'(DEPTH - FRAME_LEN);
    assign trig_addr = (start_sum >= (ADDR_W + 1)'(DEPTH))
                     ? ADDR_W'(start_sum - (ADDR_W + 1)'(DEPTH)) : ADDR_W'(start_sum);

    assign trig        = accept && (filled ? (hop_cnt == HOP_W'(HOP_LEN - 1))
                                           : (fill_cnt == NUM_W'(FRAME_LEN - 1)));
    assign last_beat   = (state == EMIT) && (emit_cnt == NUM_W'(FRAME_LEN - 1));
    assign final_frame = (n_frames_q != '0) && (frame_idx == n_frames_q - 1'b1);
    // Write-first: a sample landing on the read address this edge is forwarded.
    assign rd_data     = (accept && (wr_ptr == rd_ptr)) ? bus.data_i : mem[rd_ptr];

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nx    = state;
        start_frame = 1'b0;
        start_addr  = trig_addr;
        pend_set    = 1'b0;
        pend_clr    = 1'b0;
        ovf_set     = 1'b0;
        unique case (state)
            FILL, GAP: begin
                if (trig) begin
                    state_nx    = EMIT;
                    start_frame = 1'b1;
                end
            end
            EMIT: begin
                if (trig && pending) ovf_set = 1'b1;
                if (last_beat) begin
                    if (final_frame) begin
                        state_nx = STOP;
                    end else if (pending) begin
                        start_frame = 1'b1;
                        start_addr  = pend_addr;
                        pend_clr    = 1'b1;
                    end else if (trig) begin
                        // A hop landing on the last beat chains straight into the next frame.
                        start_frame = 1'b1;
                    end else begin
                        state_nx = GAP;
                    end
                end else if (trig && !pending) begin
                    pend_set = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // NOTE: the sample store carries no reset; its contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= bus.data_i;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= FILL;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            pend_addr  <= '0;
            fill_cnt   <= '0;
            emit_cnt   <= '0;
            hop_cnt    <= '0;
            filled     <= 1'b0;
            pending    <= 1'b0;
            started    <= 1'b0;
            n_frames_q <= '0;
            frame_idx  <= '0;
            do_en      <= 2'd0;
            data_o     <= '0;
            num        <= '0;
            frame_last <= 1'b0;
            done       <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                wr_ptr <= wr_next;
                if (!filled) begin
                    if (fill_cnt == NUM_W'(FRAME_LEN - 1)) filled <= 1'b1;
                    else                                   fill_cnt <= fill_cnt + 1'b1;
                end else begin
                    hop_cnt <= (hop_cnt == HOP_W'(HOP_LEN - 1)) ? '0 : hop_cnt + 1'b1;
                end
            end
            if (!started) n_frames_q <= bus.cfg_n_frames;
            if (start_frame) started <= 1'b1;

            if (pend_clr) begin
                pending <= 1'b0;
            end else if (pend_set) begin
                pending   <= 1'b1;
                pend_addr <= trig_addr;
            end
            if (ovf_set) ovf <= 1'b1;

            unique case (state)
                EMIT: begin
                    do_en      <= 2'd1;
                    data_o     <= rd_data;
                    num        <= emit_cnt;
                    frame_last <= last_beat;
                    rd_ptr     <= rd_next;
                    emit_cnt   <= emit_cnt + 1'b1;
                end
                GAP, STOP: begin
                    do_en      <= 2'd2;
                    frame_last <= 1'b0;
                end
                default: begin
                    do_en      <= 2'd0;
                    frame_last <= 1'b0;
                end
            endcase
            if (start_frame) begin
                rd_ptr   <= start_addr;
                emit_cnt <= '0;
            end

            if (frame_last) begin
                frame_idx <= frame_idx + 1'b1;
                if (final_frame) done <= 1'b1;
            end
        end
    end

    assign bus.do_en      = do_en;
    assign bus.data_o     = data_o;
    assign bus.num        = num;
    assign bus.frame_last = frame_last;
    assign bus.frame_idx  = frame_idx;
    assign bus.done       = done;
    assign bus.ovf        = ovf;
endmodule

// File: tb/tb_overlap_framer.sv
// Directed bench for overlap_framer: three small configurations (8/2, 8/4, 64/10)
// driven from vector tables plus hand-written reset and frame-limit sequences.
module tb_overlap_framer;
    localparam int DW = 14;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst_a, rst_b, rst_c;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    overlap_framer_if #(.DATA_W(DW), .FRAME_LEN(8),  .FRAME_CNT_W(CW)) ifa ();
    overlap_framer_if #(.DATA_W(DW), .FRAME_LEN(8),  .FRAME_CNT_W(CW)) ifb ();
    overlap_framer_if #(.DATA_W(DW), .FRAME_LEN(64), .FRAME_CNT_W(CW)) ifc ();

    overlap_framer #(.DATA_W(DW), .FRAME_LEN(8), .HOP_LEN(2), .FRAME_CNT_W(CW))
        dut_a (.clk(clk), .rst(rst_a), .bus(ifa));
    overlap_framer #(.DATA_W(DW), .FRAME_LEN(8), .HOP_LEN(4), .FRAME_CNT_W(CW))
        dut_b (.clk(clk), .rst(rst_b), .bus(ifb));
    overlap_framer #(.DATA_W(DW), .FRAME_LEN(64), .HOP_LEN(10), .FRAME_CNT_W(CW))
        dut_c (.clk(clk), .rst(rst_c), .bus(ifc));

    typedef struct {
        logic [1:0] di_en;
        int         data_i;
        logic [1:0] en;
        int         data;
        int         num;
        logic       last;
        int         idx;
        logic       ovf;
    } vec_t;

    vec_t vec [64];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stimulus for the 64/10 instance: 64 samples, then 88 bursts of 10 valid + 54 wait.
    task automatic drive_c(input int t);
        int u;
        u = t - 64;
        if (t < 64) begin
            ifc.di_en = 2'd1; ifc.data_i = DW'(t);
        end else if (u / 64 < 88) begin
            ifc.di_en  = (u % 64 < 10) ? 2'd1 : 2'd2;
            ifc.data_i = DW'(64 + 10 * (u / 64) + u % 64);
        end else begin
            ifc.di_en = 2'd0; ifc.data_i = '0;
        end
    endtask

    initial begin
        int n_valid, n_start, bad, max_idx, ovf_seen, late_valid;

        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        ifa.di_en = 2'd0; ifa.data_i = '0; ifa.cfg_n_frames = '0;
        ifb.di_en = 2'd0; ifb.data_i = '0; ifb.cfg_n_frames = '0;
        ifc.di_en = 2'd0; ifc.data_i = '0; ifc.cfg_n_frames = '0;
        tick();
        tick();
        check("rst_do_en", ifa.do_en, 0);
        check("rst_data", ifa.data_o, 0);
        check("rst_num", ifa.num, 0);
        check("rst_last", ifa.frame_last, 0);
        check("rst_idx", ifa.frame_idx, 0);
        check("rst_done", ifa.done, 0);
        check("rst_ovf", ifa.ovf, 0);

        // 8/2 continuous: first frame 0..7, pending on sample 9, ovf on sample 11.
        for (int e = 0; e < 16; e++) begin
            vec[e].di_en  = 2'd1;
            vec[e].data_i = e;
            vec[e].en     = (e < 8) ? 2'd0 : 2'd1;
            vec[e].data   = (e < 8) ? 0 : e - 8;
            vec[e].num    = (e < 8) ? 0 : e - 8;
            vec[e].last   = (e == 15);
            vec[e].idx    = 0;
            vec[e].ovf    = (e >= 11);
        end
        rst_a = 1'b1;
        for (int e = 0; e < 16; e++) begin
            ifa.di_en = vec[e].di_en; ifa.data_i = DW'(vec[e].data_i);
            tick();
            check($sformatf("a%0d_en", e), ifa.do_en, vec[e].en);
            check($sformatf("a%0d_data", e), ifa.data_o, vec[e].data);
            check($sformatf("a%0d_num", e), ifa.num, vec[e].num);
            check($sformatf("a%0d_last", e), ifa.frame_last, vec[e].last);
            check($sformatf("a%0d_idx", e), ifa.frame_idx, vec[e].idx);
            check($sformatf("a%0d_ovf", e), ifa.ovf, vec[e].ovf);
        end
        ifa.data_i = DW'(16);
        tick();
        check("a16_b2b_en", ifa.do_en, 1);
        check("a16_b2b_num", ifa.num, 0);
        check("a16_idx", ifa.frame_idx, 1);

        // Reset for one edge at num=5 aborts the frame and requires a fresh fill.
        ifa.di_en = 2'd0; rst_a = 1'b0;
        tick();
        rst_a = 1'b1;
        for (int e = 0; e < 14; e++) begin
            ifa.di_en = 2'd1; ifa.data_i = DW'(e);
            tick();
        end
        check("r13_en", ifa.do_en, 1);
        check("r13_num", ifa.num, 5);
        check("r13_data", ifa.data_o, 5);
        check("r13_ovf_pre", ifa.ovf, 1);
        rst_a = 1'b0; ifa.data_i = DW'(14);
        tick();
        check("r14_en", ifa.do_en, 0);
        check("r14_num", ifa.num, 0);
        check("r14_idx", ifa.frame_idx, 0);
        check("r14_ovf", ifa.ovf, 0);
        check("r14_done", ifa.done, 0);
        rst_a = 1'b1;
        for (int e = 15; e < 23; e++) begin
            ifa.data_i = DW'(e);
            tick();
            check($sformatf("r%0d_fill_en", e), ifa.do_en, 0);
        end
        ifa.data_i = DW'(23);
        tick();
        check("r23_en", ifa.do_en, 1);
        check("r23_num", ifa.num, 0);
        check("r23_data", ifa.data_o, 15);
        ifa.di_en = 2'd0;

        // 8/4 with a sample every other cycle; odd cycles carry di_en 0/3/2 and junk data.
        for (int e = 0; e < 55; e++) begin
            int k;
            k = e - 15;
            if (e % 2 == 0) begin
                vec[e].di_en = 2'd1; vec[e].data_i = e / 2;
            end else begin
                case ((e / 2) % 3)
                    0:       vec[e].di_en = 2'd0;
                    1:       vec[e].di_en = 2'd3;
                    default: vec[e].di_en = 2'd2;
                endcase
                vec[e].data_i = 999;
            end
            vec[e].en   = (e < 15) ? 2'd0 : 2'd1;
            vec[e].data = (e < 15) ? 0 : 4 * (k / 8) + k % 8;
            vec[e].num  = (e < 15) ? 0 : k % 8;
            vec[e].last = (e >= 15) && (k % 8 == 7);
            vec[e].idx  = (e < 15) ? 0 : k / 8;
            vec[e].ovf  = 1'b0;
        end
        rst_b = 1'b1;
        for (int e = 0; e < 55; e++) begin
            ifb.di_en = vec[e].di_en; ifb.data_i = DW'(vec[e].data_i);
            tick();
            check($sformatf("b%0d_en", e), ifb.do_en, vec[e].en);
            check($sformatf("b%0d_data", e), ifb.data_o, vec[e].data);
            check($sformatf("b%0d_num", e), ifb.num, vec[e].num);
            check($sformatf("b%0d_last", e), ifb.frame_last, vec[e].last);
            check($sformatf("b%0d_idx", e), ifb.frame_idx, vec[e].idx);
            check($sformatf("b%0d_ovf", e), ifb.ovf, vec[e].ovf);
        end
        ifb.di_en = 2'd0;

        // 64/10 unlimited: 89 frames, frame f holds data 10f..10f+63.
        n_valid = 0; n_start = 0; bad = 0; max_idx = 0; ovf_seen = 0;
        rst_c = 1'b1;
        for (int t = 0; t < 5800; t++) begin
            drive_c(t);
            tick();
            if (ifc.ovf) ovf_seen = 1;
            if (ifc.do_en == 2'd1) begin
                n_valid++;
                if (ifc.num == 0) n_start++;
                if (int'(ifc.frame_idx) > max_idx) max_idx = int'(ifc.frame_idx);
                if (int'(ifc.data_o) != 10 * int'(ifc.frame_idx) + int'(ifc.num)) bad++;
            end
        end
        check("c_valid_cycles", n_valid, 89 * 64);
        check("c_frames", n_start, 89);
        check("c_data_errors", bad, 0);
        check("c_max_idx", max_idx, 88);
        check("c_ovf", ovf_seen, 0);
        check("c_final_idx", ifc.frame_idx, 89);
        check("c_done", ifc.done, 0);

        // 64/10 limited to three frames.
        ifc.di_en = 2'd0; rst_c = 1'b0;
        tick();
        ifc.cfg_n_frames = CW'(3);
        rst_c = 1'b1;
        late_valid = 0;
        for (int t = 0; t < 600; t++) begin
            drive_c(t);
            tick();
            if (t == 255) begin
                check("l255_last", ifc.frame_last, 1);
                check("l255_idx", ifc.frame_idx, 2);
                check("l255_done", ifc.done, 0);
            end
            if (t == 256) begin
                check("l256_done", ifc.done, 1);
                check("l256_en", ifc.do_en, 2);
                check("l256_idx", ifc.frame_idx, 3);
            end
            if (t > 255 && ifc.do_en == 2'd1) late_valid++;
        end
        check("l_no_more_frames", late_valid, 0);
        check("l_end_en", ifc.do_en, 2);
        check("l_end_done", ifc.done, 1);
        check("l_end_idx", ifc.frame_idx, 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/overlap_framer.md
Name: overlap_framer

Overview:
- Parametrised successor to the input counter stage of the log-mel front end.
- Buffers a stream of signed audio samples and emits overlapping analysis frames of FRAME_LEN samples, one new frame every HOP_LEN accepted samples, oldest sample first.
- Adds over the previous block: runtime frame limit with done flag, one-deep pending-frame queue for back-to-back frames, last-sample marker, frame index, and sticky overflow detection.
- Sits between the ADC/sample source and the windowing/FFT stage.

Parameters:
- DATA_W, 14, sample width (signed, two's complement) in and out.
- FRAME_LEN, 1024, samples per emitted frame (>=2).
- HOP_LEN, 160, new samples between frame starts (1..FRAME_LEN).
- FRAME_CNT_W, 16, width of the frame counter and the frame limit.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  reset, synchronous and active-low (state cleared on a rising clk edge with rst==0).
- di_en  in  2  input qualifier: 0 invalid, 1 sample valid, 2 input wait, 3 reserved (treated as 0).
- data_i  in  DATA_W  signed sample, taken only when di_en==1.
- cfg_n_frames  in  FRAME_CNT_W  frames to emit before stopping; 0 means unlimited. Sampled only while no frame has started.
- do_en  out  2  output qualifier: 0 invalid, 1 sample valid, 2 waiting between frames.
- data_o  out  DATA_W  signed frame sample.
- num  out  $clog2(FRAME_LEN)  index of data_o within the current frame.
- frame_last  out  1  high with the num==FRAME_LEN-1 sample.
- frame_idx  out  FRAME_CNT_W  index of the frame being emitted; starts at 0 and wraps.
- done  out  1  sticky; set after frame cfg_n_frames-1 finishes.
- ovf  out  1  sticky; hop boundary reached while a frame is already pending.

Behaviour:
- Reset (rst==0 at an edge): all outputs 0, pointers, counters, pending flag and fill flag cleared. Buffer contents are don't-care. Reset during an emission aborts it with no further do_en==1.
- Storage: circular buffer, DEPTH = FRAME_LEN + 2*HOP_LEN words, write pointer wraps at DEPTH. A sample accepted at edge k is readable at edge k+1 (write-first).
- Trigger condition:
  - Fill phase: trigger when the FRAME_LEN-th sample since reset is accepted.
  - After that: trigger on every HOP_LEN-th accepted sample.
  - Frame start address = write pointer minus FRAME_LEN (mod DEPTH) at the trigger.
- FSM states:
  - FILL: do_en=0. On trigger go to EMIT.
  - EMIT: one sample per cycle, num 0..FRAME_LEN-1. The first sample (do_en=1, num=0) is registered at edge k+1, where k is the trigger edge. After the last sample:
    - pending set: go to EMIT with no gap; next num=0 on the following edge; pending cleared.
    - pending clear: go to GAP.
  - GAP: do_en=2, data_o and num hold their last values. On trigger go to EMIT.
  - STOP: do_en=2. Entered when done is set; input is still written, all triggers are ignored.
- Trigger during EMIT:
  - pending clear: pending is set and the start address is latched.
  - pending set: ovf is set, the trigger is dropped, and the stored pending frame is kept.
- Sample order within a frame: the num=i sample equals the (start+i)-th sample accepted since reset (0-based), modulo DEPTH addressing.
- Counters:
  - frame_idx increments after each frame_last and wraps modulo 2^FRAME_CNT_W.
  - done is set on the edge after frame_last when frame_idx==cfg_n_frames-1 and cfg_n_frames!=0.
- Inputs with di_en in {0,2,3} are ignored and advance no counter. Output pacing does not depend on input gaps.
- Guaranteed data integrity: accepted input rate no more than HOP_LEN samples per FRAME_LEN cycles sustained, plus one pending frame of burst slack. Outside this, ovf flags the loss.

Test Plan:
- FRAME_LEN=8, HOP_LEN=2, continuous di_en=1 with data_i=0,1,2,… :
  - First frame is 0..7, num=0 one edge after sample 7 is accepted, frame_last with data 7.
  - The second hop sets pending; the third hop (sample 11) sets ovf.
- Defaults, stimulus of 1024 samples then repeated bursts of 160 valid + 864 wait (di_en=2), data n-1, 15104 samples in total:
  - Exactly 89 frames (91136 do_en==1 cycles).
  - Frame f starts at data 160*f; frame_idx reaches 88; ovf=0.
- Defaults with cfg_n_frames=3:
  - done rises after the third frame's frame_last; do_en stays 2 afterwards.
  - frame_idx=3; no further do_en==1 despite continued input.
- FRAME_LEN=8, HOP_LEN=4, input pulses every other cycle:
  - Back-to-back frames with no do_en==2 cycle between them.
  - Second frame data 4..11.
  - Buffer wrap at DEPTH=16 produces correct data.
- rst=0 for one edge mid-emission (num=5):
  - Next edge shows do_en=0, num=0, frame_idx=0, ovf=0, done=0.
  - A fresh 8-sample fill is required before the next do_en==1.
- di_en=3 and di_en=0 interleaved with valid samples: the ignored values never appear in data_o, and trigger timing counts only di_en==1 samples.
